// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Instruction fetch sequencer for the RISC-16 core. It owns the program
// counter and drives the combinational instruction memory address. Each
// returned 24-bit word is registered into a one-entry fetch buffer, which is
// presented to decode. It also takes PC redirects from execute, and stops
// fetching after an HLT until it is restarted.
//
// Handshake (decode side): if_valid/if_instr/if_pc form a valid/ready source.
// A transfer happens on a rising edge where if_valid & if_ready are both 1.
// While if_valid=1 and if_ready=0, if_instr and if_pc are held stable.
// if_valid never drops without a transfer, except on a redirect or a reset.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   start           pulse: leave IDLE/HALT and fetch from the current PC
//   imem_addr       instruction memory address (= PC register)
//   imem_instr      async-read memory data for imem_addr
//   if_valid/if_instr/if_pc/if_ready   fetch buffer -> decode handshake
//   redirect, redirect_pc              PC load + buffer flush from execute
//   busy, halted    registered status decoded from the FSM state
//   instr_count     completed transfers, wraps modulo 2^16
//   dbg_state_o     raw FSM state (IDLE=0, RUN=1, DRAIN=2, HALT=3)
// ---------------------------------------------------------------------------
module fetch_controller #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       INSTR_W    = 24,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]        HLT_OPCODE = 4'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        instr_count,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   ifpc_q, ifpc_d;
  logic [15:0]         count_q, count_d;

  logic transfer;
  logic load;

  assign transfer = valid_q & if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        // Buffer is empty here, so only the PC and the state can change.
        if (redirect) pc_d = redirect_pc;
        if (start)    state_d = S_RUN;
      end
      S_RUN: begin
        // Redirect wins over a load: the word at the old PC is stale.
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
        end else if (!valid_q || if_ready) begin
          load = 1'b1;
        end
      end
      S_DRAIN: begin
        // Redirect squashes the buffered HLT and resumes fetching.
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = S_RUN;
        end else if (transfer) begin
          valid_d = 1'b0;
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      instr_d = imem_instr;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + ADDR_W'(1);
      // The HLT itself still goes to decode; fetching stops behind it.
      if (imem_instr[INSTR_W-1 -: 4] == HLT_OPCODE) state_d = S_DRAIN;
    end
  end

  // A transfer completing in the same cycle as a redirect is still counted.
  assign count_d = count_q + 16'(transfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign halted      = (state_q == S_HALT);
  assign instr_count = count_q;
  assign dbg_state_o = state_q;

endmodule
